// File: rtl/reduce_gate_pipe.sv
// Pipelined N_IN-word bitwise reduction (OR/AND/XOR and inversions) through a registered
// 2-input gate tree, with op/acc_en carried alongside the data and a sticky OR accumulator.
module reduce_gate_pipe #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [2:0]              op,
  input  logic                    acc_en,
  input  logic [N_IN*WIDTH-1:0]   a,
  input  logic                    acc_clr,
  output logic [WIDTH-1:0]        y,
  output logic                    out_valid,
  output logic                    op_err,
  output logic [WIDTH-1:0]        acc_out,
  output logic                    acc_hit
);

  localparam int L = $clog2(N_IN);

  // Node count at tree level k; odd counts leave one node to pass through unpaired.
  function automatic int nodesAt(input int k);
    int n;
    n = N_IN;
    for (int i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] baseOp(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z,
                                              input logic [2:0]       sel);
    logic [WIDTH-1:0] res;
    case (sel)
      3'b001, 3'b100: res = x & z;
      3'b010, 3'b101: res = x ^ z;
      default:        res = x | z;
    endcase
    return res;
  endfunction

  // Level 0 is the raw input; levels 1..L-1 are registered here, level L is the output stage.
  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int NK = nodesAt(k);
    logic [WIDTH-1:0] w_node [NK];
    logic [2:0]       w_op;
    logic             w_accEn;
    logic             w_vld;

    if (k == 0) begin : g_in
      for (genvar i = 0; i < NK; i++) begin : g_w
        assign w_node[i] = a[i*WIDTH +: WIDTH];
      end
      assign w_op    = op;
      assign w_accEn = acc_en;
      assign w_vld   = in_valid;
    end else begin : g_reg
      localparam int NP = nodesAt(k - 1);
      logic [2:0] r_op;
      logic       r_accEn;
      logic       r_vld;

      for (genvar i = 0; i < NK; i++) begin : g_n
        logic [WIDTH-1:0] r_node;
        if (2*i + 1 < NP) begin : g_pair
          always_ff @(posedge clk or posedge rst) begin
            if (rst) r_node <= '0;
            else     r_node <= baseOp(g_lvl[k-1].w_node[2*i], g_lvl[k-1].w_node[2*i+1],
                                      g_lvl[k-1].w_op);
          end
        end else begin : g_pass
          always_ff @(posedge clk or posedge rst) begin
            if (rst) r_node <= '0;
            else     r_node <= g_lvl[k-1].w_node[2*i];
          end
        end
        assign w_node[i] = r_node;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_op    <= 3'b000;
          r_accEn <= 1'b0;
          r_vld   <= 1'b0;
        end else begin
          r_op    <= g_lvl[k-1].w_op;
          r_accEn <= g_lvl[k-1].w_accEn;
          r_vld   <= g_lvl[k-1].w_vld;
        end
      end

      assign w_op    = r_op;
      assign w_accEn = r_accEn;
      assign w_vld   = r_vld;
    end
  end

  logic [2:0]       w_lastOp;
  logic             w_lastVld;
  logic             w_reserved;
  logic             w_invert;
  logic             w_qual;
  logic [WIDTH-1:0] w_tree;
  logic [WIDTH-1:0] w_yNew;
  logic [WIDTH-1:0] w_accNext;

  logic [WIDTH-1:0] r_y;
  logic             r_outValid;
  logic             r_opErr;
  logic [WIDTH-1:0] r_acc;
  logic             r_accHit;

  // The last level always holds exactly two nodes; the accumulator sees the value entering y.
  always_comb begin
    w_lastOp   = g_lvl[L-1].w_op;
    w_lastVld  = g_lvl[L-1].w_vld;
    w_reserved = w_lastOp[2] & w_lastOp[1];
    w_invert   = (w_lastOp == 3'b011) || (w_lastOp == 3'b100) || (w_lastOp == 3'b101);
    w_tree     = baseOp(g_lvl[L-1].w_node[0], g_lvl[L-1].w_node[1], w_lastOp);
    w_yNew     = w_tree;
    if (w_reserved)    w_yNew = '0;
    else if (w_invert) w_yNew = ~w_tree;
    w_qual     = w_lastVld & g_lvl[L-1].w_accEn & ~w_reserved;
    w_accNext  = r_acc;
    if (acc_clr && w_qual) w_accNext = w_yNew;
    else if (acc_clr)      w_accNext = '0;
    else if (w_qual)       w_accNext = r_acc | w_yNew;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y        <= '0;
      r_outValid <= 1'b0;
      r_opErr    <= 1'b0;
      r_acc      <= '0;
      r_accHit   <= 1'b0;
    end else begin
      r_outValid <= w_lastVld;
      r_opErr    <= w_lastVld & w_reserved;
      if (w_lastVld) r_y <= w_yNew;
      r_acc      <= w_accNext;
      r_accHit   <= |w_accNext;
    end
  end

  assign y         = r_y;
  assign out_valid = r_outValid;
  assign op_err    = r_opErr;
  assign acc_out   = r_acc;
  assign acc_hit   = r_accHit;

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Directed self-checking bench for reduce_gate_pipe: a 4x8 instance and a 3x1 instance
// (legacy 3-input OR equivalent) share one clock.
module tb_reduce_gate_pipe;

  logic        clk;
  logic        rst;

  logic        inValid;
  logic [2:0]  opSel;
  logic        accEn;
  logic [31:0] aBus;
  logic        accClr;
  logic [7:0]  yOut;
  logic        outValid;
  logic        opErr;
  logic [7:0]  accOut;
  logic        accHit;

  logic        inValid3;
  logic [2:0]  a3;
  logic [0:0]  yOut3;
  logic        outValid3;
  logic        opErr3;
  logic [0:0]  accOut3;
  logic        accHit3;

  int checks;
  int failures;

  reduce_gate_pipe #(.N_IN(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .op(opSel), .acc_en(accEn), .a(aBus),
    .acc_clr(accClr), .y(yOut), .out_valid(outValid), .op_err(opErr),
    .acc_out(accOut), .acc_hit(accHit)
  );

  reduce_gate_pipe #(.N_IN(3), .WIDTH(1)) dut3 (
    .clk(clk), .rst(rst), .in_valid(inValid3), .op(3'b000), .acc_en(1'b0), .a(a3),
    .acc_clr(1'b0), .y(yOut3), .out_valid(outValid3), .op_err(opErr3),
    .acc_out(accOut3), .acc_hit(accHit3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs to the 4x8 instance, then step to 1 time unit past the edge.
  task automatic applyStimulus(input logic v, input logic [2:0] o, input logic ae,
                               input logic [31:0] av, input logic clr);
    inValid = v;
    opSel   = o;
    accEn   = ae;
    aBus    = av;
    accClr  = clr;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweepExp [6];

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    inValid  = 1'b0;
    opSel    = 3'b000;
    accEn    = 1'b0;
    aBus     = '0;
    accClr   = 1'b0;
    inValid3 = 1'b0;
    a3       = 3'b000;
    sweepExp = '{8'hFF, 8'h00, 8'h3C, 8'h00, 8'hFF, 8'hC3};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_y", yOut, 8'h00);
    checkOutput("rst_out_valid", outValid, 1'b0);
    checkOutput("rst_op_err", opErr, 1'b0);
    checkOutput("rst_acc_out", accOut, 8'h00);
    checkOutput("rst_acc_hit", accHit, 1'b0);
    checkOutput("rst_out_valid3", outValid3, 1'b0);
    #3 rst = 1'b0;

    // Reset mid-stream: the transaction at level 1 and the one on the inputs must vanish.
    applyStimulus(1'b1, 3'b000, 1'b0, 32'h0000_1001, 1'b0);
    #3 rst = 1'b1;
    #2;
    checkOutput("midrst_out_valid", outValid, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
      checkOutput("postrst_no_valid", outValid, 1'b0);
    end

    applyStimulus(1'b1, 3'b000, 1'b0, 32'h0000_1001, 1'b0);
    checkOutput("lat_cycle1_valid", outValid, 1'b0);
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
    checkOutput("lat_cycle2_valid", outValid, 1'b1);
    checkOutput("lat_cycle2_y", yOut, 8'h11);
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
    checkOutput("lat_cycle3_valid", outValid, 1'b0);
    checkOutput("lat_y_hold", yOut, 8'h11);
    checkOutput("lat_op_err_low", opErr, 1'b0);

    // Op sweep back-to-back on one operand set.
    for (int c = 0; c < 8; c++) begin
      if (c < 6) applyStimulus(1'b1, 3'(c), 1'b0, 32'hFFF0_3C0F, 1'b0);
      else       applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
      if (c >= 1 && c <= 6) begin
        checkOutput($sformatf("sweep_valid_op%0d", c - 1), outValid, 1'b1);
        checkOutput($sformatf("sweep_y_op%0d", c - 1), yOut, sweepExp[c-1]);
      end
    end
    checkOutput("sweep_end_valid", outValid, 1'b0);
    checkOutput("sweep_acc_untouched", accOut, 8'h00);

    // Odd N_IN=3, WIDTH=1: legacy 3-input OR, latency 2.
    for (int c = 0; c < 10; c++) begin
      inValid3 = (c < 8);
      a3       = 3'(c);
      applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
      if (c >= 1 && c <= 8) begin
        checkOutput($sformatf("or3_valid_%0d", c - 1), outValid3, 1'b1);
        checkOutput($sformatf("or3_y_%0d", c - 1), yOut3, (c - 1 == 0) ? 1'b0 : 1'b1);
      end
    end
    checkOutput("or3_end_valid", outValid3, 1'b0);
    inValid3 = 1'b0;

    // Accumulator, reserved op, clear-with-result, clear alone.
    applyStimulus(1'b1, 3'b000, 1'b1, 32'h0000_0001, 1'b0);
    applyStimulus(1'b1, 3'b000, 1'b1, 32'h0000_0080, 1'b0);
    checkOutput("acc_first_y", yOut, 8'h01);
    checkOutput("acc_first", accOut, 8'h01);
    applyStimulus(1'b1, 3'b111, 1'b1, 32'hFFFF_FFFF, 1'b0);
    checkOutput("acc_second_y", yOut, 8'h80);
    checkOutput("acc_81", accOut, 8'h81);
    checkOutput("acc_hit_81", accHit, 1'b1);
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
    checkOutput("resv_valid", outValid, 1'b1);
    checkOutput("resv_y", yOut, 8'h00);
    checkOutput("resv_op_err", opErr, 1'b1);
    checkOutput("resv_acc_hold", accOut, 8'h81);
    applyStimulus(1'b1, 3'b000, 1'b1, 32'h0000_0004, 1'b0);
    checkOutput("resv_err_one_cycle", opErr, 1'b0);
    checkOutput("resv_next_valid", outValid, 1'b0);
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b1);
    checkOutput("clr_with_result_y", yOut, 8'h04);
    checkOutput("clr_with_result_acc", accOut, 8'h04);
    checkOutput("clr_with_result_hit", accHit, 1'b1);
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b1);
    checkOutput("clr_alone_acc", accOut, 8'h00);
    checkOutput("clr_alone_hit", accHit, 1'b0);

    // Async reset between edges during accumulation.
    applyStimulus(1'b1, 3'b000, 1'b1, 32'h0000_0001, 1'b0);
    applyStimulus(1'b1, 3'b000, 1'b1, 32'h0000_0002, 1'b0);
    checkOutput("pre_arst_acc", accOut, 8'h01);
    checkOutput("pre_arst_valid", outValid, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_acc_out", accOut, 8'h00);
    checkOutput("arst_acc_hit", accHit, 1'b0);
    checkOutput("arst_y", yOut, 8'h00);
    checkOutput("arst_out_valid", outValid, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
      checkOutput("arst_no_valid", outValid, 1'b0);
      checkOutput("arst_acc_stays", accOut, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reduce_gate_pipe.md
Name: reduce_gate_pipe

Overview:
- Parametrised, pipelined successor to the team's fixed 3-input OR gate.
- Reduces N_IN input words of WIDTH bits bitwise through a registered 2-input gate tree.
- Operation is selectable per transaction: OR, AND, XOR, NOR, NAND or XNOR.
- A sticky OR accumulator collects results across transactions. The block sits between bus-level flag sources and status/interrupt logic.

Parameters:
- N_IN, 4, number of input words reduced; legal range 2..16.
- WIDTH, 8, bits per word; legal range 1..64.
- Derived constant L = ceil(log2(N_IN)), the pipeline latency in cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  transaction present on a/op/acc_en this cycle
- op  input  3  operation: 000 OR, 001 AND, 010 XOR, 011 NOR, 100 NAND, 101 XNOR; 110/111 reserved
- acc_en  input  1  fold this transaction's result into the accumulator
- a  input  N_IN*WIDTH  flattened words; word i occupies bits [i*WIDTH +: WIDTH]
- acc_clr  input  1  synchronous accumulator clear
- y  output  WIDTH  reduction result
- out_valid  output  1  y/op_err valid this cycle
- op_err  output  1  reserved op code seen; qualified by out_valid
- acc_out  output  WIDTH  sticky OR of accumulated results
- acc_hit  output  1  registered; high when acc_out != 0

Behaviour:
- Reset (async assert, sync release): all pipeline data and valid bits = 0; y = 0, out_valid = 0, op_err = 0, acc_out = 0, acc_hit = 0. Reset mid-operation discards every in-flight transaction; no out_valid follows reset release until a new in_valid arrives.
- Tree structure:
  - Level k (k = 1..L) combines adjacent node pairs with the base op: OR for OR/NOR, AND for AND/NAND, XOR for XOR/XNOR.
  - An unpaired node at any level passes through unchanged. No identity padding is used, so odd N_IN (for example 3) is exact.
  - Every level is registered. Latency is exactly L cycles from in_valid to out_valid.
- Sideband pipelining: op and acc_en travel in the pipeline alongside the data, so back-to-back transactions with different ops do not interact.
- Throughput: one transaction per cycle. There is no backpressure; the consumer must accept out_valid.
- Final stage:
  - NOR, NAND and XNOR invert the tree result in the last register stage.
  - Reserved op: y = 0 and op_err = 1 for that result only.
- When out_valid = 0, y holds its last value and op_err = 0.
- Accumulator update, evaluated each cycle in this priority:
  - acc_clr with a qualifying result: acc_out <= y_new, i.e. clear then accumulate.
  - acc_clr alone: acc_out <= 0.
  - Qualifying result alone: acc_out <= acc_out | y_new.
  - Otherwise acc_out holds.
  - A qualifying result is out_valid & acc_en & ~op_err for the transaction emerging this cycle. y_new is the value being registered into y.
- acc_hit: registered from the next-state acc_out, so it is aligned with acc_out.
- Width rule: all ops are bitwise per bit lane, with no arithmetic and no carries.

Test Plan:
- Reset and latency (N_IN=4, WIDTH=8): assert rst mid-stream, release, then drive a = {8'h00,8'h00,8'h10,8'h01}, op=000 in cycle 0 -> out_valid only in cycle 2 with y=8'h11. No out_valid appears for the transactions in flight at reset.
- Op sweep, back-to-back: same a = {8'hFF,8'hF0,8'h3C,8'h0F}, ops 000..101 on 6 consecutive cycles -> y = FF, 00, 3C, 00, FF, C3 on 6 consecutive valid cycles.
- Odd N_IN=3, WIDTH=1: all 8 combinations of {c,b,a} with op=000 -> y=0 only for 000, otherwise 1. This matches the legacy 3-input OR truth table with latency 2.
- Reserved op: op=111 with any a -> y=0 and op_err=1 for exactly one valid cycle. acc_out is unchanged even with acc_en=1.
- Accumulator: with acc_en=1, results 8'h01 then 8'h80 -> acc_out=8'h81, acc_hit=1. Then acc_clr coincident with result 8'h04 -> acc_out=8'h04. Then acc_clr alone -> acc_out=0, acc_hit=0.
- Async reset during accumulation: rst pulsed between clock edges -> acc_out, y and out_valid go to 0 immediately, without waiting for a clock edge.
